// File: rtl/test_sequencer.sv
// ---------------------------------------------------------------------------
// test_sequencer
//
// On-chip stimulus/check controller for a combinational DUT. A run has two
// phases. The exhaustive phase applies every input vector from 0 up to
// 2^INBITS-1. The random phase then applies RAND_COUNT vectors taken from a
// 32-bit Galois LFSR. Each vector goes through three steps:
//   COOL   : COOLDOWN cycles with the stimulus marked invalid
//   SETTLE : DELAY cycles with the vector applied and marked valid
//   CHECK  : one cycle in which the DUT output is compared with the golden model
// The first mismatch stops the run in FAIL and records the failing vector,
// the expected value and the observed value.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - begin a run (only honoured in IDLE, DONE or FAIL)
//   abort      - synchronous return to IDLE; overrides start and the check
//   comp_in    - stimulus driven to the DUT and the golden model
//   comp_valid - comp_in holds a real vector (SETTLE and CHECK)
//   verify     - golden-model output
//   comp_out   - DUT output
//   busy       - run in progress (COOL, SETTLE, CHECK)
//   done       - run finished with no mismatch (held until start/abort)
//   fail       - mismatch detected (held until start/abort)
//   phase      - 0 = exhaustive sweep, 1 = random sweep
//   fail_vec   - comp_in at the first mismatch
//   fail_exp   - verify at the first mismatch
//   fail_got   - comp_out at the first mismatch
// ---------------------------------------------------------------------------
module test_sequencer #(
    parameter int          INBITS     = 4,
    parameter int          OUTBITS    = 4,
    parameter int          DELAY      = 2,
    parameter int          COOLDOWN   = 1,
    parameter int          RAND_COUNT = 64,
    parameter logic [31:0] SEED       = 32'hACE1_0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [INBITS-1:0]  comp_in,
    output logic               comp_valid,
    input  logic [OUTBITS-1:0] verify,
    input  logic [OUTBITS-1:0] comp_out,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               phase,
    output logic [INBITS-1:0]  fail_vec,
    output logic [OUTBITS-1:0] fail_exp,
    output logic [OUTBITS-1:0] fail_got
);

    // The vector counter is shared by both phases. It needs INBITS+1 bits to
    // cover the exhaustive sweep, and it must also be wide enough to count
    // up to RAND_COUNT, which may be larger than 2^(INBITS+1).
    localparam int CNTW_EXH = INBITS + 1;
    localparam int CNTW_RND = (RAND_COUNT > 0) ? $clog2(RAND_COUNT + 1) : 1;
    localparam int CNTW     = (CNTW_EXH > CNTW_RND) ? CNTW_EXH : CNTW_RND;

    // The wait counter runs from 0 to (interval-1) for the longer of the
    // two intervals.
    localparam int WAIT_MAX = (COOLDOWN > DELAY) ? COOLDOWN : DELAY;
    localparam int WAITW    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [WAITW-1:0] COOL_LAST   = WAITW'(COOLDOWN - 1);
    localparam logic [WAITW-1:0] SETTLE_LAST = WAITW'(DELAY - 1);
    localparam logic [WAITW-1:0] WAIT_ONE    = WAITW'(1);
    localparam logic [CNTW-1:0]  CNT_ONE     = CNTW'(1);
    localparam logic [CNTW-1:0]  RAND_LAST   = CNTW'((RAND_COUNT > 0) ? RAND_COUNT - 1 : 0);

    // Galois feedback mask for taps 32, 22, 2, 1 (bit n-1 for tap n)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        COOL,
        SETTLE,
        CHECK,
        DONE,
        FAIL
    } state_t;

    state_t              state, state_d;
    logic [INBITS-1:0]   comp_in_d;
    logic [CNTW-1:0]     counter, counter_d;
    logic [31:0]         lfsr, lfsr_d;
    logic [WAITW-1:0]    wait_cnt, wait_d;
    logic                phase_d;
    logic [INBITS-1:0]   fail_vec_d;
    logic [OUTBITS-1:0]  fail_exp_d;
    logic [OUTBITS-1:0]  fail_got_d;

    // One step of the right-shifting Galois LFSR: the bit shifted out of
    // the bottom is folded back into the tap positions.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {1'b0, cur[31:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    // The status outputs are decoded directly from the state. That makes
    // done and fail "sticky" for as long as the FSM stays in DONE/FAIL. It
    // also clears them on every path out of those states (start, abort,
    // reset) without any extra registers.
    assign comp_valid = (state == SETTLE) || (state == CHECK);
    assign busy       = (state == COOL) || (state == SETTLE) || (state == CHECK);
    assign done       = (state == DONE);
    assign fail       = (state == FAIL);

    // Next-state and datapath logic. Every register gets a hold default
    // first. abort is tested ahead of the state case, so it wins over start
    // and over the CHECK result. The stimulus is driven to zero during COOL
    // and is only loaded with the next vector on the COOL->SETTLE edge. As a
    // result, comp_in never shows a vector while comp_valid is low, except
    // for the failing vector held in FAIL.
    always_comb begin
        state_d    = state;
        comp_in_d  = comp_in;
        counter_d  = counter;
        lfsr_d     = lfsr;
        wait_d     = wait_cnt;
        phase_d    = phase;
        fail_vec_d = fail_vec;
        fail_exp_d = fail_exp;
        fail_got_d = fail_got;

        if (abort) begin
            state_d   = IDLE;
            comp_in_d = '0;
            wait_d    = '0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state_d   = COOL;
                        comp_in_d = '0;
                        counter_d = '0;
                        phase_d   = 1'b0;
                        lfsr_d    = SEED;
                        wait_d    = '0;
                    end
                end

                COOL: begin
                    if (wait_cnt == COOL_LAST) begin
                        state_d   = SETTLE;
                        wait_d    = '0;
                        comp_in_d = phase ? lfsr[INBITS-1:0] : counter[INBITS-1:0];
                    end else begin
                        wait_d = wait_cnt + WAIT_ONE;
                    end
                end

                SETTLE: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        state_d = CHECK;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_cnt + WAIT_ONE;
                    end
                end

                CHECK: begin
                    if (comp_out != verify) begin
                        state_d    = FAIL;
                        fail_vec_d = comp_in;
                        fail_exp_d = verify;
                        fail_got_d = comp_out;
                    end else begin
                        comp_in_d = '0;
                        if (!phase) begin
                            // In the exhaustive phase the counter stays below
                            // 2^INBITS, so "low bits all ones" means the
                            // increment would reach 2^INBITS.
                            if (&counter[INBITS-1:0]) begin
                                phase_d   = 1'b1;
                                counter_d = '0;
                                state_d   = (RAND_COUNT == 0) ? DONE : COOL;
                            end else begin
                                counter_d = counter + CNT_ONE;
                                state_d   = COOL;
                            end
                        end else begin
                            lfsr_d    = lfsr_step(lfsr);
                            counter_d = counter + CNT_ONE;
                            state_d   = (counter == RAND_LAST) ? DONE : COOL;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. An asynchronous reset drops everything,
    // including the captured failure record, back to its power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            comp_in  <= '0;
            counter  <= '0;
            lfsr     <= SEED;
            wait_cnt <= '0;
            phase    <= 1'b0;
            fail_vec <= '0;
            fail_exp <= '0;
            fail_got <= '0;
        end else begin
            state    <= state_d;
            comp_in  <= comp_in_d;
            counter  <= counter_d;
            lfsr     <= lfsr_d;
            wait_cnt <= wait_d;
            phase    <= phase_d;
            fail_vec <= fail_vec_d;
            fail_exp <= fail_exp_d;
            fail_got <= fail_got_d;
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_test_sequencer
//
// Directed bench for test_sequencer. The main instance uses INBITS=2,
// OUTBITS=2, DELAY=1, COOLDOWN=1 and RAND_COUNT=4. Each vector therefore
// takes 3 cycles: COOL, SETTLE, CHECK. The golden model is verify =
// comp_in ^ 2'b11. The stand-in DUT copies it, except when a fault mode is
// selected. A second instance with INBITS=1 and RAND_COUNT=0 covers the
// case where the run ends straight after the exhaustive phase.
// ---------------------------------------------------------------------------
module tb_test_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] comp_in;
    logic       comp_valid;
    logic [1:0] verify;
    logic [1:0] comp_out;
    logic       busy;
    logic       done;
    logic       fail;
    logic       phase;
    logic [1:0] fail_vec;
    logic [1:0] fail_exp;
    logic [1:0] fail_got;

    logic       start1;
    logic       abort1;
    logic       comp_in1;
    logic       comp_valid1;
    logic       verify1;
    logic       comp_out1;
    logic       busy1;
    logic       done1;
    logic       fail1;
    logic       phase1;
    logic       fail_vec1;
    logic       fail_exp1;
    logic       fail_got1;

    int n_checks;
    int n_fail;
    int inj_mode;

    typedef struct {
        logic       start_in;
        logic [1:0] exp_vec;
        logic       exp_phase;
    } vec_rec_t;

    vec_rec_t vtab [8];

    test_sequencer #(
        .INBITS    (2),
        .OUTBITS   (2),
        .DELAY     (1),
        .COOLDOWN  (1),
        .RAND_COUNT(4),
        .SEED      (32'hACE1_0001)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .comp_in   (comp_in),
        .comp_valid(comp_valid),
        .verify    (verify),
        .comp_out  (comp_out),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .phase     (phase),
        .fail_vec  (fail_vec),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

    test_sequencer #(
        .INBITS    (1),
        .OUTBITS   (1),
        .DELAY     (1),
        .COOLDOWN  (1),
        .RAND_COUNT(0),
        .SEED      (32'hACE1_0001)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .abort     (abort1),
        .comp_in   (comp_in1),
        .comp_valid(comp_valid1),
        .verify    (verify1),
        .comp_out  (comp_out1),
        .busy      (busy1),
        .done      (done1),
        .fail      (fail1),
        .phase     (phase1),
        .fail_vec  (fail_vec1),
        .fail_exp  (fail_exp1),
        .fail_got  (fail_got1)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden model and stand-in DUT. Fault mode 1 corrupts the output for
    // vector 2'b10. Fault mode 2 corrupts it for 2'b11, but only in the
    // random phase, which lands on the second random vector.
    always_comb begin
        verify   = comp_in ^ 2'b11;
        comp_out = verify;
        if (inj_mode == 1 && comp_valid && comp_in == 2'b10) begin
            comp_out = 2'b11;
        end
        if (inj_mode == 2 && comp_valid && phase && comp_in == 2'b11) begin
            comp_out = verify ^ 2'b10;
        end
        verify1   = ~comp_in1;
        comp_out1 = verify1;
    end

    function automatic logic [31:0] modelLfsr(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) begin
            s = s ^ 32'h8020_0003;
        end
        return s;
    endfunction

    // Drive the inputs for one rising edge, then return on the next falling
    // edge, where the outputs are sampled.
    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " comp_valid"}, 64'(comp_valid), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd0);
        checkOutput({tag, " fail"}, 64'(fail), 64'd0);
        checkOutput({tag, " phase"}, 64'(phase), 64'd0);
        checkOutput({tag, " comp_in"}, 64'(comp_in), 64'd0);
        checkOutput({tag, " fail_vec"}, 64'(fail_vec), 64'd0);
        checkOutput({tag, " fail_exp"}, 64'(fail_exp), 64'd0);
        checkOutput({tag, " fail_got"}, 64'(fail_got), 64'd0);
    endtask

    // Full clean run. The caller has just issued start, so the sample point
    // is in cycle 1 (the first COOL). Each table row covers one vector.
    // use_start lets the table re-assert start while busy, which must be
    // ignored. After 24 busy cycles, cycle 25 must show DONE.
    task automatic runNormal(input string tag, input logic use_start);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("%s v%0d cool busy", tag, i), 64'(busy), 64'd1);
            checkOutput($sformatf("%s v%0d cool valid", tag, i), 64'(comp_valid), 64'd0);
            checkOutput($sformatf("%s v%0d cool comp_in", tag, i), 64'(comp_in), 64'd0);
            checkOutput($sformatf("%s v%0d phase", tag, i), 64'(phase), 64'(vtab[i].exp_phase));
            applyStimulus(use_start & vtab[i].start_in, 1'b0);
            checkOutput($sformatf("%s v%0d settle valid", tag, i), 64'(comp_valid), 64'd1);
            checkOutput($sformatf("%s v%0d settle comp_in", tag, i), 64'(comp_in), 64'(vtab[i].exp_vec));
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("%s v%0d check valid", tag, i), 64'(comp_valid), 64'd1);
            checkOutput($sformatf("%s v%0d check comp_in", tag, i), 64'(comp_in), 64'(vtab[i].exp_vec));
            checkOutput($sformatf("%s v%0d check busy", tag, i), 64'(busy), 64'd1);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput({tag, " end done"}, 64'(done), 64'd1);
        checkOutput({tag, " end busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " end fail"}, 64'(fail), 64'd0);
        checkOutput({tag, " end valid"}, 64'(comp_valid), 64'd0);
        checkOutput({tag, " end phase"}, 64'(phase), 64'd1);
    endtask

    initial begin
        logic [31:0] lf1;
        logic [1:0]  exp_vec;
        logic [1:0]  exp_exp;

        n_checks = 0;
        n_fail   = 0;
        inj_mode = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        start1   = 1'b0;
        abort1   = 1'b0;

        // Exhaustive 0..3. The random vectors are the low bits of SEED and
        // its successors: ACE10001 -> D6508003 -> EB084002 -> 75842001.
        // That gives 1, 3, 2, 1. Row 2 re-asserts start while busy.
        vtab[0] = '{1'b0, 2'd0, 1'b0};
        vtab[1] = '{1'b0, 2'd1, 1'b0};
        vtab[2] = '{1'b1, 2'd2, 1'b0};
        vtab[3] = '{1'b0, 2'd3, 1'b0};
        vtab[4] = '{1'b0, 2'd1, 1'b1};
        vtab[5] = '{1'b0, 2'd3, 1'b1};
        vtab[6] = '{1'b0, 2'd2, 1'b1};
        vtab[7] = '{1'b0, 2'd1, 1'b1};

        // Power-up reset
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean run, including an ignored start while busy
        $display("[TB] clean run");
        applyStimulus(1'b1, 1'b0);
        runNormal("clean", 1'b1);

        // Mismatch on exhaustive vector 2: FAIL entered on cycle 10
        $display("[TB] exhaustive mismatch");
        inj_mode = 1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("exh restart done cleared", 64'(done), 64'd0);
        checkOutput("exh restart busy", 64'(busy), 64'd1);
        repeat (9) applyStimulus(1'b0, 1'b0);
        checkOutput("exh fail", 64'(fail), 64'd1);
        checkOutput("exh done", 64'(done), 64'd0);
        checkOutput("exh busy", 64'(busy), 64'd0);
        checkOutput("exh valid", 64'(comp_valid), 64'd0);
        checkOutput("exh fail_vec", 64'(fail_vec), 64'd2);
        checkOutput("exh fail_exp", 64'(fail_exp), 64'd1);
        checkOutput("exh fail_got", 64'(fail_got), 64'd3);
        checkOutput("exh comp_in held", 64'(comp_in), 64'd2);
        checkOutput("exh phase", 64'(phase), 64'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("exh fail sticky", 64'(fail), 64'd1);

        // Mismatch on the second random vector: FAIL entered on cycle 19
        $display("[TB] random mismatch");
        inj_mode = 2;
        lf1      = modelLfsr(32'hACE1_0001);
        exp_vec  = lf1[1:0];
        exp_exp  = exp_vec ^ 2'b11;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rnd restart fail cleared", 64'(fail), 64'd0);
        checkOutput("rnd restart comp_in", 64'(comp_in), 64'd0);
        checkOutput("rnd restart fail_vec kept", 64'(fail_vec), 64'd2);
        repeat (18) applyStimulus(1'b0, 1'b0);
        checkOutput("rnd fail", 64'(fail), 64'd1);
        checkOutput("rnd phase", 64'(phase), 64'd1);
        checkOutput("rnd fail_vec", 64'(fail_vec), 64'(exp_vec));
        checkOutput("rnd fail_exp", 64'(fail_exp), 64'(exp_exp));
        checkOutput("rnd fail_got", 64'(fail_got), 64'(exp_exp ^ 2'b10));
        checkOutput("rnd done", 64'(done), 64'd0);

        // Abort together with start during the SETTLE of vector 1
        $display("[TB] abort");
        inj_mode = 0;
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("abort pre valid", 64'(comp_valid), 64'd1);
        checkOutput("abort pre comp_in", 64'(comp_in), 64'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort valid", 64'(comp_valid), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort fail", 64'(fail), 64'd0);
        checkOutput("abort fail_vec kept", 64'(fail_vec), 64'(exp_vec));
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort idle busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 1'b0);
        runNormal("rerun", 1'b0);

        // Half-cycle asynchronous reset pulse in the middle of a run
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midrun reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset busy", 64'(busy), 64'd0);
        checkOutput("post reset valid", 64'(comp_valid), 64'd0);
        applyStimulus(1'b1, 1'b0);
        runNormal("post reset", 1'b0);

        // INBITS=1, RAND_COUNT=0: two vectors, then DONE in cycle 7
        $display("[TB] no random phase");
        start1 = 1'b1;
        applyStimulus(1'b0, 1'b0);
        start1 = 1'b0;
        checkOutput("nr c1 busy", 64'(busy1), 64'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("nr c2 valid", 64'(comp_valid1), 64'd1);
        checkOutput("nr c2 comp_in", 64'(comp_in1), 64'd0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("nr c5 valid", 64'(comp_valid1), 64'd1);
        checkOutput("nr c5 comp_in", 64'(comp_in1), 64'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("nr c6 busy", 64'(busy1), 64'd1);
        checkOutput("nr c6 done", 64'(done1), 64'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("nr c7 done", 64'(done1), 64'd1);
        checkOutput("nr c7 busy", 64'(busy1), 64'd0);
        checkOutput("nr c7 phase", 64'(phase1), 64'd1);
        checkOutput("nr c7 fail", 64'(fail1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Synthesizable on-chip stimulus/check controller for a combinational DUT.
- Sequences an exhaustive sweep of every input vector, then a pseudo-random sweep from an LFSR.
- Each vector gets a cooldown interval, then a settle interval, then a one-cycle compare of DUT output against a golden model.
- Sits between the DUT and its reference model inside self-test wrappers on hardware builds; reports pass/fail and captures the first failing vector.

Parameters:
- INBITS, 4, DUT input width (1..32).
- OUTBITS, 4, DUT output width (>=1).
- DELAY, 2, settle cycles after a vector is applied (>=1).
- COOLDOWN, 1, cycles with stimulus invalid between vectors (>=1).
- RAND_COUNT, 64, number of random vectors after the exhaustive phase (>=0).
- SEED, 32'hACE1_0001, LFSR reset value (nonzero).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE, DONE or FAIL.
- abort  input  1  synchronous return to IDLE.
- comp_in  output  INBITS  stimulus to the DUT and the golden model.
- comp_valid  output  1  high while comp_in holds a real vector (SETTLE, CHECK).
- verify  input  OUTBITS  golden-model output.
- comp_out  input  OUTBITS  DUT output.
- busy  output  1  high in COOL, SETTLE and CHECK.
- done  output  1  run completed with no mismatch; sticky.
- fail  output  1  mismatch detected; sticky.
- phase  output  1  0 = exhaustive, 1 = random.
- fail_vec  output  INBITS  comp_in at the first mismatch.
- fail_exp  output  OUTBITS  verify at the first mismatch.
- fail_got  output  OUTBITS  comp_out at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; comp_in=0; comp_valid=0; busy=done=fail=phase=0.
  - fail_* = 0; vector counter = 0; lfsr = SEED; wait counter = 0.
- States: IDLE, COOL, SETTLE, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL with start=1 at an edge:
  - Next cycle is COOL; done/fail cleared; counter=0; phase=0; lfsr=SEED; fail_* retain old value until a new mismatch.
- COOL:
  - comp_valid=0; comp_in=0.
  - Stays exactly COOLDOWN cycles, then SETTLE.
  - On the COOL->SETTLE edge: comp_in loads counter[INBITS-1:0] (phase 0) or lfsr[INBITS-1:0] (phase 1).
- SETTLE:
  - comp_valid=1; comp_in stable.
  - Stays exactly DELAY cycles, then CHECK.
- CHECK (1 cycle):
  - Compares comp_out against verify (bitwise equality).
  - Mismatch: next state FAIL; fail_vec/fail_exp/fail_got captured on that edge; fail=1.
  - Match, phase 0: counter increments. Counter is INBITS+1 bits wide. If the increment reaches 2^INBITS, phase becomes 1 and counter resets to 0. If RAND_COUNT=0 at that point, go to DONE; otherwise go to COOL.
  - Match, phase 1: lfsr advances one step (32-bit Galois, taps 32,22,2,1) and counter increments. Counter reaching RAND_COUNT -> DONE, else COOL.
- Cycle cost per vector: COOLDOWN+DELAY+1.
- Total run length: (2^INBITS + RAND_COUNT) * (COOLDOWN+DELAY+1) cycles from the first COOL cycle to DONE entry.
- DONE: done=1, busy=0, comp_valid=0; holds until start or abort.
- FAIL: fail=1, busy=0, comp_valid=0; comp_in holds the failing vector; holds until start or abort.
- abort=1 at any edge: next state IDLE; comp_valid=busy=done=fail=0; fail_* unchanged.
  - abort has priority over start and over the CHECK result.
- start while busy: ignored.
- rst_n asserted mid-run: immediate return to reset values; no partial-result retention.

Test Plan:
- INBITS=2, OUTBITS=2, DELAY=1, COOLDOWN=1, RAND_COUNT=4, golden=DUT, 1-cycle start pulse -> comp_in walks 0,1,2,3 then 4 LFSR vectors; busy high 24 cycles; done=1 in cycle 25; fail=0.
- Same config, DUT output forced wrong when comp_in=2'b10 (expect 2'b01, got 2'b11) -> fail=1 after the 3rd CHECK; fail_vec=2'b10, fail_exp=2'b01, fail_got=2'b11; done=0; comp_in holds 2'b10.
- Mismatch injected only on the 2nd random vector -> phase=1 at failure; fail_vec equals the LFSR value after one step from SEED, low 2 bits.
- abort asserted during the SETTLE of vector 1, same cycle as start -> IDLE next cycle; busy=0; comp_valid=0; a later start reruns from comp_in=0 with lfsr=SEED.
- rst_n pulsed low for a half-cycle mid-run -> all outputs 0 asynchronously; state IDLE; start afterwards completes normally in 24 cycles.
- RAND_COUNT=0, INBITS=1 -> exactly 2 vectors; done in cycle 7; phase=1 in DONE.
